// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: pattern mode encodings and the default 640x480@60 raster timing
// used as parameter defaults by vga_timing_gen and vga_pattern_gen.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } vga_mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_timing_gen_pattern.sv
// vga_pattern_gen: combinational test-pattern colour for one raster position.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a frame_cnt input that scrolls
// the gradient pattern.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int CH_W     = 1,
  parameter int CNT_W    = 10
) (
  input  logic [CNT_W-1:0]  x,
  input  logic [CNT_W-1:0]  y,
  input  logic [1:0]        mode,
  input  logic [3*CH_W-1:0] color,
`ifdef VGA_TIMING_FRAME_CNT_EN
  input  logic [15:0]       frame_cnt,
`endif
  output logic [3*CH_W-1:0] rgb
);

  logic [7:1]       bar_ge;
  logic [2:0]       bar_idx;
  logic [2:0]       bar_code;
  logic [CNT_W-1:0] grad_x;
  logic             unused_bits;

  // Bar boundaries are constant compares; the bar index is the count of
  // boundaries already passed, since the thresholds are monotonic.
  genvar gi;
  for (gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_ge[gi] = (x >= CNT_W'(gi * H_ACTIVE / 8));
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  assign grad_x = x + CNT_W'(frame_cnt);
`else
  assign grad_x = x;
`endif

  // Only y[5] and the top bits of grad_x feed the patterns.
  assign unused_bits = ^{y[CNT_W-1:6], y[4:0], grad_x[CNT_W-CH_W-1:0]};

  // Select the raw colour for the current shadow mode.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[k]};
    end
    bar_code = 3'd7 - bar_idx;
    rgb      = '0;
    case (vga_mode_e'(mode))
      MODE_SOLID: rgb = color;
      MODE_BARS:  rgb = {{CH_W{bar_code[2]}}, {CH_W{bar_code[1]}}, {CH_W{bar_code[0]}}};
      MODE_CHECK: rgb = (x[5] ^ y[5]) ? '0 : color;
      MODE_GRAD:  rgb = {3{grad_x[CNT_W-1 -: CH_W]}};
      default:    rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters, syncs, strobes and a
// registered test-pattern output. Optional macro VGA_TIMING_FRAME_CNT_EN
// adds a 16-bit frame_cnt output and makes the gradient scroll.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CH_W     = 1,
  parameter int CNT_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic [1:0]        mode,
  input  logic [3*CH_W-1:0] color,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic              video_on,
  output logic              h_sync,
  output logic              v_sync,
  output logic              line_start,
  output logic              frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  output logic [3*CH_W-1:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0]  pixel_x_q, pixel_y_q;
  logic              video_on_q, video_on_d;
  logic              h_sync_q, h_sync_d;
  logic              v_sync_q, v_sync_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [3*CH_W-1:0] rgb_q, rgb_d;
  logic [1:0]        mode_q, mode_sel;
  logic [3*CH_W-1:0] color_q, color_sel;
  logic [3*CH_W-1:0] pat_rgb;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

  // Next raster position and its decodes; the frame-start edge uses the
  // incoming mode/colour so the whole new frame sees the new pattern.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
    video_on_d    = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    h_sync_d      = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? H_POL : ~H_POL;
    v_sync_d      = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? V_POL : ~V_POL;
    line_start_d  = pix_ce && (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_cnt_d == '0);
    mode_sel      = frame_start_d ? mode  : mode_q;
    color_sel     = frame_start_d ? color : color_q;
    rgb_d         = video_on_d ? pat_rgb : '0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .CH_W     (CH_W),
    .CNT_W    (CNT_W)
  ) u_pattern (
    .x         (h_cnt_d),
    .y         (v_cnt_d),
    .mode      (mode_sel),
    .color     (color_sel),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt (frame_cnt_d),
`endif
    .rgb       (pat_rgb)
  );

  // Counters, output register (held while pix_ce=0), strobes and shadows.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      mode_q        <= '0;
      color_q       <= '0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (pix_ce) begin
        pixel_x_q  <= h_cnt_d;
        pixel_y_q  <= v_cnt_d;
        video_on_q <= video_on_d;
        h_sync_q   <= h_sync_d;
        v_sync_q   <= v_sync_d;
        rgb_q      <= rgb_d;
      end
      if (frame_start_d) begin
        mode_q  <= mode;
        color_q <= color;
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_on_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default horizontal timing with a short 8-line
// vertical raster so several frames fit in a short run. Directed expected
// pixels are queued against absolute clock-edge numbers; a monitor pops and
// compares them, and also checks sync/blanking windows and strobe periods.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4,   VF = 1,  VS = 2,  VB = 1;
  localparam int HT = 800, VT = 8,  FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset, pix_ce;
  logic [1:0] mode;
  logic [2:0] color;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, h_sync, v_sync, line_start, frame_start;
  logic [2:0] rgb;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CH_W(1), .CNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .mode(mode), .color(color),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .h_sync(h_sync), .v_sync(v_sync), .line_start(line_start),
    .frame_start(frame_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .rgb(rgb)
  );

  typedef struct {
    int         t;
    string      name;
    logic [27:0] v;   // {x, y, vo, hs, vs, ls, fs, rgb}
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   steady = 1'b0;
  int   e0;

  function automatic string fmt(logic [27:0] v);
    return $sformatf("x=%0d y=%0d vo=%b hs=%b vs=%b ls=%b fs=%b rgb=%b",
                     v[27:18], v[17:8], v[7], v[6], v[5], v[4], v[3], v[2:0]);
  endfunction

  function automatic int pos(int f, int y, int x);
    return e0 + 1 + f * FT + y * HT + x;
  endfunction

  task automatic push(int t, string nm, int x, int y, bit vo, bit hs, bit vs,
                      bit ls, bit fs, logic [2:0] c);
    exp_t e;
    e.t = t;
    e.name = nm;
    e.v = {10'(x), 10'(y), vo, hs, vs, ls, fs, c};
    sb_q.push_back(e);
  endtask

  task automatic goto_edge(int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  // Edge counter shared by stimulus and monitor.
  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Monitor: scoreboard pops plus window and period checks.
  initial begin
    exp_t e;
    logic [27:0] act;
    int   last_ls, last_fs;
    bit   have_ls, have_fs;
    have_ls = 1'b0;
    have_fs = 1'b0;
    last_ls = 0;
    last_fs = 0;
    forever begin
      @(negedge clk);
      act = {pixel_x, pixel_y, video_on, h_sync, v_sync, line_start, frame_start, rgb};
      while (sb_q.size() > 0 && sb_q[0].t < edge_cnt) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: expected at edge %0d was never compared (now %0d)", e.name, e.t, edge_cnt);
      end
      if (sb_q.size() > 0 && sb_q[0].t == edge_cnt) begin
        e = sb_q.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s edge %0d: got %s want %s", e.name, edge_cnt, fmt(act), fmt(e.v));
        end else begin
          $display("TXN %s edge %0d ok: %s", e.name, edge_cnt, fmt(act));
        end
      end
      if (steady) begin
        checks++;
        if (h_sync !== !(pixel_x >= 10'(HA + HF) && pixel_x < 10'(HA + HF + HS))) begin
          errors++;
          if (errors <= 25) $display("FAIL hsync_window x=%0d: got %b", pixel_x, h_sync);
        end
        checks++;
        if (v_sync !== !(pixel_y >= 10'(VA + VF) && pixel_y < 10'(VA + VF + VS))) begin
          errors++;
          if (errors <= 25) $display("FAIL vsync_window y=%0d: got %b", pixel_y, v_sync);
        end
        checks++;
        if (video_on !== (pixel_x < 10'(HA) && pixel_y < 10'(VA))) begin
          errors++;
          if (errors <= 25) $display("FAIL video_on (%0d,%0d): got %b", pixel_x, pixel_y, video_on);
        end
        if (!video_on) begin
          checks++;
          if (rgb !== 3'b000) begin
            errors++;
            if (errors <= 25) $display("FAIL blank_rgb (%0d,%0d): got %b want 000", pixel_x, pixel_y, rgb);
          end
        end
        if (line_start) begin
          if (have_ls) begin
            checks++;
            if (edge_cnt - last_ls != HT) begin
              errors++;
              $display("FAIL line_period: got %0d want %0d", edge_cnt - last_ls, HT);
            end
          end
          have_ls = 1'b1;
          last_ls = edge_cnt;
        end
        if (frame_start) begin
          if (have_fs) begin
            checks++;
            if (edge_cnt - last_fs != FT) begin
              errors++;
              $display("FAIL frame_period: got %0d want %0d", edge_cnt - last_fs, FT);
            end else begin
              $display("TXN frame_period edge %0d ok: %0d", edge_cnt, FT);
            end
          end
          have_fs = 1'b1;
          last_fs = edge_cnt;
        end
      end else begin
        have_ls = 1'b0;
        have_fs = 1'b0;
      end
    end
  end

  // Watchdog: the directed run needs about 27k edges.
  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within 40000 clk");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int pa, pb;
    reset  = 1'b1;
    pix_ce = 1'b1;
    mode   = 2'd1;
    color  = 3'b101;
    e0     = 0;
    push(1, "rst_edge1", 0, 0, 0, 1, 1, 0, 0, 3'b000);
    push(2, "rst_edge2", 0, 0, 0, 1, 1, 0, 0, 3'b000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    e0 = edge_cnt;
    // frame 0: colour bars
    push(pos(0,0,0),   "bars_x0",      0,   0, 1, 1, 1, 1, 1, 3'b111);
    push(pos(0,0,80),  "bars_x80",     80,  0, 1, 1, 1, 0, 0, 3'b110);
    push(pos(0,0,639), "bars_x639",    639, 0, 1, 1, 1, 0, 0, 3'b000);
    push(pos(0,0,640), "hblank_x640",  640, 0, 0, 1, 1, 0, 0, 3'b000);
    push(pos(0,0,655), "hs_pre_655",   655, 0, 0, 1, 1, 0, 0, 3'b000);
    push(pos(0,0,656), "hs_first_656", 656, 0, 0, 0, 1, 0, 0, 3'b000);
    push(pos(0,0,751), "hs_last_751",  751, 0, 0, 0, 1, 0, 0, 3'b000);
    push(pos(0,0,752), "hs_post_752",  752, 0, 0, 1, 1, 0, 0, 3'b000);
    push(pos(0,1,0),   "line1_start",  0,   1, 1, 1, 1, 1, 0, 3'b111);
    push(pos(0,3,80),  "bars_hold",    80,  3, 1, 1, 1, 0, 0, 3'b110);
    push(pos(0,4,0),   "vblank_y4",    0,   4, 0, 1, 1, 1, 0, 3'b000);
    push(pos(0,5,10),  "vs_y5",        10,  5, 0, 1, 0, 0, 0, 3'b000);
    push(pos(0,6,10),  "vs_y6",        10,  6, 0, 1, 0, 0, 0, 3'b000);
    push(pos(0,7,10),  "vs_off_y7",    10,  7, 0, 1, 1, 0, 0, 3'b000);
    push(pos(0,7,700), "hs_in_vblank", 700, 7, 0, 0, 1, 0, 0, 3'b000);
    // frame 1: solid
    push(pos(1,0,0),   "solid_f1",     0,   0, 1, 1, 1, 1, 1, 3'b101);
    push(pos(1,3,40),  "solid_hold",   40,  3, 1, 1, 1, 0, 0, 3'b101);
    // frame 2: checkerboard
    push(pos(2,0,32),  "check_x32",    32,  0, 1, 1, 1, 0, 0, 3'b000);
    push(pos(2,1,0),   "check_x0_y1",  0,   1, 1, 1, 1, 1, 0, 3'b101);
    push(pos(2,1,64),  "check_x64",    64,  1, 1, 1, 1, 0, 0, 3'b101);
    push(pos(2,3,600), "check_hold",   600, 3, 1, 1, 1, 0, 0, 3'b101);
    // frame 3: gradient
    push(pos(3,0,100), "grad_x100",    100, 0, 1, 1, 1, 0, 0, 3'b000);
    push(pos(3,0,600), "grad_x600",    600, 0, 1, 1, 1, 0, 0, 3'b111);
    push(pos(3,1,700), "grad_blank",   700, 1, 0, 0, 1, 0, 0, 3'b000);
    @(negedge clk);
    steady = 1'b1;
    goto_edge(pos(0,2,0)); mode = 2'd0;
    goto_edge(pos(1,2,0)); mode = 2'd2;
    goto_edge(pos(2,2,0)); mode = 2'd3;

    // pix_ce toggling across a line start and a frame start
    pa = pos(3,4,798);
    pb = pa + 2404;
    goto_edge(pa);
    steady = 1'b0;
    push(pa + 1,    "ce_799",     799, 4, 0, 1, 1, 0, 0, 3'b000);
    push(pa + 2,    "ce_line",    0,   5, 0, 1, 0, 1, 0, 3'b000);
    push(pa + 3,    "ce_hold1",   0,   5, 0, 1, 0, 0, 0, 3'b000);
    push(pa + 4,    "ce_hold2",   0,   5, 0, 1, 0, 0, 0, 3'b000);
    push(pa + 5,    "ce_resume",  1,   5, 0, 1, 0, 0, 0, 3'b000);
    push(pb - 1,    "last_pix",   799, 7, 0, 1, 1, 0, 0, 3'b000);
    push(pb,        "ce_frame",   0,   0, 1, 1, 1, 1, 1, 3'b000);
    push(pb + 1,    "ce_fhold",   0,   0, 1, 1, 1, 0, 0, 3'b000);
    push(pb + 2,    "ce_fresume", 1,   0, 1, 1, 1, 0, 0, 3'b000);
    // mid-frame reset, then first pixel with freshly latched pattern
    push(pb + 1101, "pre_rst",    300, 1, 1, 1, 1, 0, 0, 3'b000);
    push(pb + 1102, "rst_mid",    0,   0, 0, 1, 1, 0, 0, 3'b000);
    push(pb + 1103, "rst_hold",   0,   0, 0, 1, 1, 0, 0, 3'b000);
    push(pb + 1104, "rst_first",  0,   0, 1, 1, 1, 1, 1, 3'b011);
    push(pb + 1105, "rst_second", 1,   0, 1, 1, 1, 0, 0, 3'b011);
    goto_edge(pa + 2); pix_ce = 1'b0;
    goto_edge(pa + 4); pix_ce = 1'b1;
    goto_edge(pb);     pix_ce = 1'b0;
    goto_edge(pb + 1); pix_ce = 1'b1;
    goto_edge(pb + 1101);
    reset = 1'b1;
    mode  = 2'd0;
    color = 3'b011;
    goto_edge(pb + 1102);
    reset  = 1'b0;
    pix_ce = 1'b0;
    goto_edge(pb + 1103);
    pix_ce = 1'b1;
    goto_edge(pb + 1108);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
